// File: rtl/servo_pkg.sv
// Shared servo timing defaults and position helpers used by servo blocks.
package servo_pkg;

   localparam int DEF_PERIOD   = 40;
   localparam int DEF_MIN_HIGH = 2;
   localparam int DEF_MAX_HIGH = 4;

   // Limit a requested position to the usable span.
   function automatic int clamp_pos(input int cmd, input int span);
      int res;
      res = (cmd > span) ? span : cmd;
      return res;
   endfunction

   // One bounded slew step from cur toward target; never overshoots.
   function automatic int slew_next(input int cur, input int target, input int step);
      int res;
      res = cur;
      if (target > cur) begin
         res = ((target - cur) > step) ? (cur + step) : target;
      end else if (target < cur) begin
         res = ((cur - target) > step) ? (cur - step) : target;
      end
      return res;
   endfunction

endpackage

// File: rtl/servo_channel.sv
// One servo channel: target/current position, busy flag and PWM output.
// Handshake note: wr is a single-cycle write strobe already qualified by the
// parent's valid&ready accept; the channel never back-pressures.
module servo_channel
   import servo_pkg::*;
#(
   parameter int CNT_W    = 6,
   parameter int POS_W    = 2,
   parameter int MIN_HIGH = 2,
   parameter int SPAN     = 2,
   parameter int STEP     = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] cnt,
   input  logic             wrap,
   input  logic             wr,
   input  logic [POS_W+1:0] wr_pos,
   output logic             busy,
   output logic             servo_out
);

   logic [POS_W-1:0] target;
   logic [POS_W-1:0] cur;
   logic [POS_W-1:0] target_nxt;
   logic [POS_W-1:0] cur_nxt;
   logic [CNT_W:0]   high_len;

   // Next-state: writes retarget at once; slew only on the frame wrap edge,
   // using the target held before this edge.
   always_comb begin
      target_nxt = target;
      cur_nxt    = cur;
      if (wr) begin
         target_nxt = POS_W'(clamp_pos(32'(wr_pos), SPAN));
      end
      if (wrap) begin
         cur_nxt = POS_W'(slew_next(32'(cur), 32'(target), STEP));
      end
   end

   assign high_len = (CNT_W+1)'(MIN_HIGH) + (CNT_W+1)'(cur);

   // Register position state, busy and the PWM level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         target    <= '0;
         cur       <= '0;
         busy      <= 1'b0;
         servo_out <= 1'b0;
      end else begin
         target    <= target_nxt;
         cur       <= cur_nxt;
         busy      <= (cur_nxt != target_nxt);
         servo_out <= ({1'b0, cnt} < high_len);
      end
   end

endmodule

// File: rtl/servo_array_ctrl.sv
// Multi-channel servo PWM controller: shared frame counter, command decode,
// per-channel slewing position and PWM.
// Handshake: a command transfers on a clock edge where cmd_valid and
// cmd_ready are both 1; cmd_ready is held 1 after reset, so one command
// can transfer every cycle and cmd_valid never needs to wait.
module servo_array_ctrl
   import servo_pkg::*;
#(
   parameter int PERIOD   = DEF_PERIOD,
   parameter int MIN_HIGH = DEF_MIN_HIGH,
   parameter int MAX_HIGH = DEF_MAX_HIGH,
   parameter int NUM_CH   = 4,
   parameter int STEP     = 1,
   localparam int SPAN    = MAX_HIGH - MIN_HIGH,
   localparam int POS_W   = (SPAN > 0) ? $clog2(SPAN + 1) : 1,
   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int CNT_W   = $clog2(PERIOD)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [CH_W-1:0]   cmd_chan,
   input  logic [POS_W+1:0]  cmd_pos,
   output logic              cmd_err,
   output logic              frame_start,
   output logic [NUM_CH-1:0] busy,
   output logic [NUM_CH-1:0] servo_out
);

   localparam logic [CH_W:0] NUM_CH_V = (CH_W+1)'(NUM_CH);

   logic [CNT_W-1:0]  cnt;
   logic              wrap;
   logic              accept;
   logic              chan_ok;
   logic [NUM_CH-1:0] wr;

   assign wrap    = (cnt == CNT_W'(PERIOD - 1));
   assign accept  = cmd_valid & cmd_ready;
   assign chan_ok = ({1'b0, cmd_chan} < NUM_CH_V);

   // Free-running frame counter, wrapping at PERIOD-1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (wrap) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Port status: ready after reset, error pulse for out-of-range channel,
   // frame_start aligned with the first (high) PWM cycle of each frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd_ready   <= 1'b0;
         cmd_err     <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         cmd_ready   <= 1'b1;
         cmd_err     <= accept & ~chan_ok;
         frame_start <= (cnt == '0);
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign wr[c] = accept && (cmd_chan == CH_W'(c));

      servo_channel #(
         .CNT_W    (CNT_W),
         .POS_W    (POS_W),
         .MIN_HIGH (MIN_HIGH),
         .SPAN     (SPAN),
         .STEP     (STEP)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .cnt       (cnt),
         .wrap      (wrap),
         .wr        (wr[c]),
         .wr_pos    (cmd_pos),
         .busy      (busy[c]),
         .servo_out (servo_out[c])
      );
   end

endmodule
